// File: rtl/mna_noc_pkg.sv
// Shared NoC flit definitions for the MNA injection path: field layout,
// flit type codes, scheduler states and small field helpers.
package mna_noc_pkg;

  localparam int FLIT_W  = 37;
  localparam int N_VC    = 8;
  localparam int VC_W    = 3;
  localparam int TYPE_HI = 36;
  localparam int TYPE_LO = 35;
  localparam int VC_HI   = 34;
  localparam int VC_LO   = 32;
  localparam int PAY_W   = 32;

  localparam logic [1:0] FT_HEAD   = 2'b10;
  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_TAIL   = 2'b01;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  localparam logic [FLIT_W-1:0] VC_FIELD_MASK = {{(FLIT_W-VC_HI-1){1'b0}}, {VC_W{1'b1}}, {PAY_W{1'b0}}};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } sched_state_t;

  // Header and single-flit types both open a packet; both have the type MSB set.
  function automatic logic opens_packet(input logic [FLIT_W-1:0] flit);
    return flit[TYPE_HI];
  endfunction

  // Tail and single-flit types both close a packet; both have the type LSB set.
  function automatic logic closes_packet(input logic [FLIT_W-1:0] flit);
    return flit[TYPE_LO];
  endfunction

  function automatic logic [FLIT_W-1:0] stamp_vc(input logic [FLIT_W-1:0] flit,
                                                 input logic [VC_W-1:0]   vc);
    return (flit & ~VC_FIELD_MASK) | (FLIT_W'(vc) << VC_LO);
  endfunction

  function automatic logic [VC_W-1:0] lowest_vc(input logic [N_VC-1:0] vcs);
    logic [VC_W-1:0] r;
    r = '0;
    for (int i = N_VC - 1; i >= 0; i--) begin
      r = vcs[i] ? VC_W'(i) : r;
    end
    return r;
  endfunction

endpackage

// File: rtl/mna_flit_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic [N-1:0] mask_s;
  logic [N-1:0] masked_s;

  // Requests at or above the pointer win; otherwise wrap to the lowest request.
  always_comb begin
    mask_s = '0;
    for (int i = 0; i < N; i++) begin
      mask_s[i] = (i >= int'(ptr));
    end
    masked_s = req & mask_s;
    if (|masked_s) begin
      gnt = masked_s & (~masked_s + N'(1));
    end else begin
      gnt = req & (~req + N'(1));
    end
  end

endmodule

// File: rtl/mna_flit_scheduler.sv
// Wormhole packet scheduler: round-robin over requesters, one downstream VC
// per packet, VC id stamped into every flit, per-VC on/off stall.
module mna_flit_scheduler
  import mna_noc_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*FLIT_W-1:0] req_flit,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_VC-1:0]         is_on_off,
  input  logic [N_VC-1:0]         is_allocatable,
  output logic [FLIT_W-1:0]       noc_data,
  output logic                    is_valid,
  output logic [N_REQ-1:0]        grant,
  output logic [VC_W-1:0]         cur_vc,
  output logic                    busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  sched_state_t      state_r;
  logic [PTR_W-1:0]  rr_ptr_r;
  logic [PTR_W-1:0]  grant_idx_r;
  logic [FLIT_W-1:0] flits_s [N_REQ];
  logic [N_REQ-1:0]  cand_s;
  logic [N_REQ-1:0]  pick_s;
  logic [PTR_W-1:0]  pick_idx_s;
  logic [N_VC-1:0]   free_vc_s;
  logic [FLIT_W-1:0] sel_flit_s;
  logic              xfer_s;

  // Unpack requester flits and find packet-opening candidates.
  always_comb begin
    cand_s     = '0;
    pick_idx_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      flits_s[i] = req_flit[i*FLIT_W +: FLIT_W];
      cand_s[i]  = req_valid[i] & opens_packet(flits_s[i]);
      pick_idx_s = pick_idx_s | (pick_s[i] ? PTR_W'(i) : '0);
    end
  end

  assign free_vc_s  = is_allocatable & is_on_off;
  assign sel_flit_s = flits_s[grant_idx_r];
  assign req_ready  = (state_r == ST_SEND) ? (grant & req_valid & {N_REQ{is_on_off[cur_vc]}})
                                           : '0;
  assign xfer_s     = |req_ready;

  rr_arbiter #(.N(N_REQ), .PTR_W(PTR_W)) u_arb (
    .req (cand_s),
    .ptr (rr_ptr_r),
    .gnt (pick_s)
  );

  // Packet FSM with registered link outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= '0;
      grant_idx_r <= '0;
      grant       <= '0;
      cur_vc      <= '0;
      busy        <= 1'b0;
      noc_data    <= '0;
      is_valid    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          is_valid <= 1'b0;
          if ((|cand_s) && (|free_vc_s)) begin
            state_r     <= ST_SEND;
            grant       <= pick_s;
            grant_idx_r <= pick_idx_s;
            cur_vc      <= lowest_vc(free_vc_s);
            busy        <= 1'b1;
          end
        end
        ST_SEND: begin
          is_valid <= xfer_s;
          if (xfer_s) begin
            noc_data <= stamp_vc(sel_flit_s, cur_vc);
            if (closes_packet(sel_flit_s)) begin
              state_r  <= ST_IDLE;
              grant    <= '0;
              busy     <= 1'b0;
              rr_ptr_r <= (grant_idx_r == PTR_W'(N_REQ - 1)) ? '0 : grant_idx_r + PTR_W'(1);
            end
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          grant    <= '0;
          busy     <= 1'b0;
          is_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mna_flit_scheduler.sv
// Directed self-checking bench for mna_flit_scheduler with hand-computed
// expected flits, grants and handshakes.
module tb_mna_flit_scheduler;

  logic        clock;
  logic        reset;
  logic [1:0]  req_valid;
  logic [73:0] req_flit;
  logic [1:0]  req_ready;
  logic [7:0]  is_on_off;
  logic [7:0]  is_allocatable;
  logic [36:0] noc_data;
  logic        is_valid;
  logic [1:0]  grant;
  logic [2:0]  cur_vc;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  mna_flit_scheduler #(.N_REQ(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_flit       (req_flit),
    .req_ready      (req_ready),
    .is_on_off      (is_on_off),
    .is_allocatable (is_allocatable),
    .noc_data       (noc_data),
    .is_valid       (is_valid),
    .grant          (grant),
    .cur_vc         (cur_vc),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_flit(input int i, input logic [36:0] f);
    req_flit[i*37 +: 37] = f;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 2'b00;
    req_flit = '0;
    is_on_off = 8'hFF;
    is_allocatable = 8'h06;
    #2;
    chk("rst_noc_data", noc_data, 0);
    chk("rst_is_valid", is_valid, 0);
    chk("rst_grant", grant, 0);
    chk("rst_cur_vc", cur_vc, 0);
    chk("rst_busy", busy, 0);
    #10 reset = 1'b0;
    tick();

    // Single packet from req0 on VC1
    req_valid = 2'b01;
    set_flit(0, 37'h11_3000_0000);
    tick();
    chk("t1_grant", grant, 2'b01);
    chk("t1_cur_vc", cur_vc, 3'd1);
    chk("t1_busy", busy, 1);
    chk("t1_ready_hdr", req_ready, 2'b01);
    chk("t1_valid_c1", is_valid, 0);
    tick();
    chk("t1_valid_c2", is_valid, 1);
    chk("t1_hdr_out", noc_data, 37'h11_3000_0000);
    set_flit(0, 37'h00_0000_BBBB);
    #1;
    chk("t1_ready_body", req_ready, 2'b01);
    tick();
    chk("t1_valid_c3", is_valid, 1);
    chk("t1_body_out", noc_data, 37'h01_0000_BBBB);
    set_flit(0, 37'h08_0000_CCCC);
    tick();
    chk("t1_valid_c4", is_valid, 1);
    chk("t1_tail_out", noc_data, 37'h09_0000_CCCC);
    chk("t1_grant_end", grant, 0);
    chk("t1_busy_end", busy, 0);
    req_valid = 2'b00;
    tick();
    chk("t1_valid_c5", is_valid, 0);
    chk("t1_noc_hold", noc_data, 37'h09_0000_CCCC);

    // Round-robin, rr_ptr is 1 after req0's packet
    req_valid = 2'b11;
    set_flit(0, 37'h10_0000_A000);
    set_flit(1, 37'h10_0000_B000);
    tick();
    chk("rr_g1", grant, 2'b10);
    chk("rr_ready1", req_ready, 2'b10);
    tick();
    set_flit(1, 37'h08_0000_B001);
    tick();
    chk("rr_bubble1", grant, 2'b00);
    chk("rr_tail1_out", noc_data, 37'h09_0000_B001);
    set_flit(1, 37'h10_0000_B000);
    tick();
    chk("rr_g2", grant, 2'b01);
    tick();
    chk("rr_hdr0_out", noc_data, 37'h11_0000_A000);
    set_flit(0, 37'h08_0000_A001);
    tick();
    chk("rr_bubble2", grant, 2'b00);
    set_flit(0, 37'h10_0000_A000);
    tick();
    chk("rr_g3", grant, 2'b10);
    tick();
    set_flit(1, 37'h08_0000_B001);
    tick();
    set_flit(1, 37'h10_0000_B000);
    tick();
    chk("rr_g4", grant, 2'b01);
    tick();
    set_flit(0, 37'h08_0000_A001);
    tick();
    req_valid = 2'b00;
    tick();

    // Flow-control stall on VC1 for 3 cycles after the header (rr_ptr = 1)
    req_valid = 2'b10;
    set_flit(1, 37'h10_0000_C000);
    tick();
    chk("fc_grant", grant, 2'b10);
    chk("fc_vc", cur_vc, 3'd1);
    tick();
    set_flit(1, 37'h00_0000_C001);
    is_on_off = 8'hFD;
    #1;
    chk("fc_ready_off", req_ready, 2'b00);
    chk("fc_hdr_out", noc_data, 37'h11_0000_C000);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("fc_stall_valid", is_valid, 0);
      chk("fc_stall_ready", req_ready, 2'b00);
    end
    chk("fc_stall_hold", noc_data, 37'h11_0000_C000);
    is_on_off = 8'hFF;
    tick();
    chk("fc_body_valid", is_valid, 1);
    chk("fc_body_out", noc_data, 37'h01_0000_C001);
    set_flit(1, 37'h08_0000_C002);
    tick();
    chk("fc_tail_out", noc_data, 37'h09_0000_C002);
    chk("fc_grant_end", grant, 0);
    req_valid = 2'b00;
    tick();

    // No VC free: single-flit header waits, then takes VC7 (rr_ptr = 0)
    is_allocatable = 8'h00;
    req_valid = 2'b01;
    set_flit(0, 37'h18_0000_D000);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("novc_grant", grant, 0);
    end
    is_allocatable = 8'h80;
    tick();
    chk("novc_grant_on", grant, 2'b01);
    chk("novc_vc7", cur_vc, 3'd7);
    tick();
    chk("single_out", noc_data, 37'h1F_0000_D000);
    chk("single_valid", is_valid, 1);
    chk("single_grant0", grant, 0);
    chk("single_busy0", busy, 0);

    // rr_ptr advanced to 1: two simultaneous single-flit packets
    is_allocatable = 8'h06;
    req_valid = 2'b11;
    set_flit(0, 37'h18_0000_E000);
    set_flit(1, 37'h18_0000_E001);
    tick();
    chk("sf_first_req1", grant, 2'b10);
    tick();
    chk("sf_out1", noc_data, 37'h19_0000_E001);
    chk("sf_grant_gap", grant, 0);
    req_valid = 2'b01;
    tick();
    chk("sf_second_req0", grant, 2'b01);
    tick();
    chk("sf_out0", noc_data, 37'h19_0000_E000);

    // A body flit presented in IDLE is never granted
    set_flit(0, 37'h00_0000_F000);
    tick();
    chk("body_idle_g", grant, 0);
    tick();
    chk("body_idle_ready", req_ready, 2'b00);
    chk("body_idle_valid", is_valid, 0);
    req_valid = 2'b00;

    // Asynchronous reset mid-body (rr_ptr = 1)
    req_valid = 2'b10;
    set_flit(1, 37'h10_0000_A100);
    tick();
    chk("rs_grant", grant, 2'b10);
    tick();
    set_flit(1, 37'h00_0000_A101);
    tick();
    chk("rs_body_out", noc_data, 37'h01_0000_A101);
    #2 reset = 1'b1;
    #1;
    chk("rs_valid", is_valid, 0);
    chk("rs_grant0", grant, 0);
    chk("rs_busy", busy, 0);
    chk("rs_noc", noc_data, 0);
    #2 reset = 1'b0;
    set_flit(1, 37'h10_0000_A200);
    tick();
    chk("rs_regrant", grant, 2'b10);
    chk("rs_vc", cur_vc, 3'd1);
    tick();
    chk("rs_hdr_out", noc_data, 37'h11_0000_A200);
    set_flit(1, 37'h08_0000_A201);
    tick();
    chk("rs_tail_out", noc_data, 37'h09_0000_A201);
    chk("rs_grant_end", grant, 0);
    req_valid = 2'b00;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mna_flit_scheduler.md
Name: mna_flit_scheduler

Overview:
- Shares one NoC injection link between N_REQ flit-producing requesters (e.g. MNA write and read request packetizers) with wormhole, packet-granular round-robin arbitration.
- Allocates a downstream virtual channel per packet from is_allocatable/is_on_off, stamps the VC id into every flit, and honours per-VC on/off flow control.
- Sits between the MNA request packetizers and the router input port.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- N_VC, 8, number of virtual channels (fixed by the 3-bit VC field).
- FLIT_W, 37, flit width: [36:35] type (10 header, 00 body, 01 tail, 11 single-flit), [34:32] VC id, [31:0] payload.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  requester i presents a flit.
- req_flit  in  N_REQ*FLIT_W  flit of requester i at [i*FLIT_W +: FLIT_W].
- req_ready  out  N_REQ  flit of requester i consumed this cycle.
- is_on_off  in  N_VC  downstream VC v may accept a flit.
- is_allocatable  in  N_VC  downstream VC v is free for a new packet.
- noc_data  out  FLIT_W  registered flit to the router.
- is_valid  out  1  noc_data valid this cycle.
- grant  out  N_REQ  one-hot owner of the link (0 when idle).
- cur_vc  out  3  VC allocated to the current packet.
- busy  out  1  packet in progress (state SEND).

Behaviour:
- Reset values: noc_data=0, is_valid=0, grant=0, cur_vc=0, busy=0, rr_ptr=0, state IDLE. Reset mid-packet aborts the packet; there is no resume.
- States: IDLE, SEND.
- IDLE:
  - Candidates are requesters with req_valid=1 and flit type 10 or 11.
  - Free VCs are those with is_allocatable[v] & is_on_off[v].
  - If at least one candidate and one free VC exist: grant the first candidate at or after rr_ptr (wrapping), take the lowest-index free VC into cur_vc, go to SEND.
  - req_ready=0 throughout IDLE. A requester presenting a body or tail flit in IDLE is never granted.
- SEND:
  - req_ready[g] = req_valid[g] & is_on_off[cur_vc], combinational. All other req_ready are 0.
  - On transfer: next cycle noc_data = {type, cur_vc, payload} (incoming [34:32] overwritten) and is_valid=1. Otherwise is_valid=0 and noc_data holds its value.
  - Transfer of a type 01 or 11 flit: go to IDLE, grant=0, rr_ptr=(g+1) mod N_REQ.
  - A header-type flit mid-packet is forwarded unchanged as payload; checking protocol is the requester's job.
- Latency: header valid at cycle 0 with VC free -> grant at edge 1 -> transfer in cycle 1 -> is_valid at cycle 2. Subsequent flits are 1 flit/cycle, 1-cycle registered latency.
- Flow control: is_on_off[cur_vc]=0 stalls the packet with no flit lost. Changes to is_allocatable mid-packet are ignored because the VC is held until the tail.
- Simultaneous events: a tail transfer and a new header in the same cycle cost one IDLE cycle, so minimum packet spacing is 1 bubble. Several candidates are resolved by rr_ptr only.
- No free VC: remain in IDLE indefinitely with no grant.

Decomposition:
- Shared package mna_noc_pkg: FLIT_W, flit type codes (FT_HEAD=2'b10, FT_BODY=2'b00, FT_TAIL=2'b01, FT_SINGLE=2'b11), field bit positions, N_VC.
- One sub-module, rr_arbiter: N-way round-robin combinational pick from request vector and pointer, one-hot output. The pointer register lives in the parent.

Test Plan:
- Single packet: req0 sends header 37'h11_3000_0000 (type 10), body, tail; is_allocatable=8'h06, is_on_off=8'hFF -> cur_vc=1. noc_data carries [34:32]=3'b001 on all 3 flits; is_valid on cycles 2,3,4; grant returns to 0.
- Round-robin: both requesters hold 2-flit packets continuously -> grant sequence 01,10,01,10 with one bubble between packets.
- Flow control stall: is_on_off[cur_vc] dropped for 3 cycles after the header -> req_ready=0 and is_valid=0 for those 3 cycles, then body and tail resume in order with no loss.
- No VC: is_allocatable=0 with a header pending for 10 cycles -> grant stays 0. Set is_allocatable=8'h80 -> cur_vc=7 and the packet proceeds.
- Single-flit packet type 11 -> one output flit, immediate return to IDLE, rr_ptr advances.
- Reset asserted mid-body -> is_valid=0, grant=0, busy=0 immediately (asynchronous). After release, a new header from req1 is granted normally.
